// File: rtl/conv_stream_driver.sv
// Host-side front end for the convolution engine: holds a host-loaded x
// vector, streams it out over a valid/ready master port, and collects the
// engine's y results into a buffer the host reads back with 1-cycle latency.
module conv_stream_driver #(
    parameter int WIDTH = 16,
    parameter int LENX  = 8,
    parameter int LENF  = 4,
    parameter int ADDRX = 3,
    parameter int LENY  = LENX - LENF + 1,
    parameter int ADDRY = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld_en,
    input  logic [ADDRX-1:0] ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] m_data_out_x,
    output logic             m_valid_x,
    input  logic             m_ready_x,
    input  logic [WIDTH-1:0] s_data_in_y,
    input  logic             s_valid_y,
    output logic             s_ready_y,
    input  logic [ADDRY-1:0] rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    localparam int DEPTHX = 1 << ADDRX;
    localparam int DEPTHY = 1 << ADDRY;
    localparam logic [ADDRX:0] LENX_C = (ADDRX + 1)'(LENX);
    localparam logic [ADDRY:0] LENY_C = (ADDRY + 1)'(LENY);
    localparam logic [ADDRX:0] ONE_X  = (ADDRX + 1)'(1);
    localparam logic [ADDRY:0] ONE_Y  = (ADDRY + 1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [ADDRX:0]   tx_ptr_q, tx_ptr_d;
    logic [ADDRX:0]   txcnt_q, txcnt_d;
    logic [ADDRY:0]   rycnt_q, rycnt_d;
    logic             m_valid_x_q, m_valid_x_d;
    logic [WIDTH-1:0] m_data_q, m_data_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic [WIDTH-1:0] buf_x_q [DEPTHX];
    logic [WIDTH-1:0] buf_x_d [DEPTHX];
    logic [WIDTH-1:0] buf_y_q [DEPTHY];
    logic [WIDTH-1:0] buf_y_d [DEPTHY];

    logic tx_fire;
    logic rx_fire;

    assign busy         = (state_q == ST_RUN);
    assign done         = (state_q == ST_DONE);
    assign s_ready_y    = (state_q == ST_RUN) && (rycnt_q < LENY_C);
    assign m_valid_x    = m_valid_x_q;
    assign m_data_out_x = m_data_q;
    assign rd_data      = rd_data_q;
    assign tx_fire      = m_valid_x_q && m_ready_x;
    assign rx_fire      = s_valid_y && s_ready_y;

    // Next-state, streaming and buffer-write logic; the output register is
    // refilled from the buffer whenever it is empty or being drained, so a
    // new word appears the cycle after every transfer.
    always_comb begin
        state_d     = state_q;
        tx_ptr_d    = tx_ptr_q;
        txcnt_d     = txcnt_q;
        rycnt_d     = rycnt_q;
        m_valid_x_d = m_valid_x_q;
        m_data_d    = m_data_q;
        buf_x_d     = buf_x_q;
        buf_y_d     = buf_y_q;
        case (state_q)
            ST_IDLE: begin
                m_valid_x_d = 1'b0;
                if (ld_en) begin
                    buf_x_d[ld_addr] = ld_data;
                end
                if (start) begin
                    state_d  = ST_RUN;
                    tx_ptr_d = '0;
                    txcnt_d  = '0;
                    rycnt_d  = '0;
                end
            end
            ST_RUN: begin
                if (tx_fire) begin
                    txcnt_d = txcnt_q + ONE_X;
                end
                if (rx_fire) begin
                    buf_y_d[rycnt_q[ADDRY-1:0]] = s_data_in_y;
                    rycnt_d = rycnt_q + ONE_Y;
                end
                if ((!m_valid_x_q || m_ready_x) && (tx_ptr_q < LENX_C)) begin
                    m_valid_x_d = 1'b1;
                    m_data_d    = buf_x_q[tx_ptr_q[ADDRX-1:0]];
                    tx_ptr_d    = tx_ptr_q + ONE_X;
                end else if (tx_fire) begin
                    m_valid_x_d = 1'b0;
                end
                if ((txcnt_d == LENX_C) && (rycnt_d == LENY_C)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                m_valid_x_d = 1'b0;
                state_d     = ST_IDLE;
            end
            default: begin
                m_valid_x_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // Registered host read port of the result buffer (old data on collision).
    always_comb begin
        rd_data_d = buf_y_q[rd_addr];
    end

    // Control state, counters and registered outputs, cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            tx_ptr_q    <= '0;
            txcnt_q     <= '0;
            rycnt_q     <= '0;
            m_valid_x_q <= 1'b0;
            m_data_q    <= '0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            tx_ptr_q    <= tx_ptr_d;
            txcnt_q     <= txcnt_d;
            rycnt_q     <= rycnt_d;
            m_valid_x_q <= m_valid_x_d;
            m_data_q    <= m_data_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // Data buffers keep their contents across reset.
    always_ff @(posedge clk) begin
        buf_x_q <= buf_x_d;
        buf_y_q <= buf_y_d;
    end

endmodule

// File: tb/tb_conv_stream_driver.sv
// Self-checking bench for conv_stream_driver: directed runs with randomized
// data and handshake patterns, compared against a transaction-level model
// (expected x word sequence, expected result buffer, completion timing).
module tb_conv_stream_driver;

    localparam int WIDTH = 16;
    localparam int LENX  = 8;
    localparam int LENF  = 4;
    localparam int ADDRX = 3;
    localparam int LENY  = LENX - LENF + 1;
    localparam int ADDRY = 3;

    logic             clk;
    logic             reset;
    logic             ld_en;
    logic [ADDRX-1:0] ld_addr;
    logic [WIDTH-1:0] ld_data;
    logic             start;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] m_data_out_x;
    logic             m_valid_x;
    logic             m_ready_x;
    logic [WIDTH-1:0] s_data_in_y;
    logic             s_valid_y;
    logic             s_ready_y;
    logic [ADDRY-1:0] rd_addr;
    logic [WIDTH-1:0] rd_data;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [WIDTH-1:0] model_x [LENX];
    logic [WIDTH-1:0] model_y [LENY];
    logic [WIDTH-1:0] y_vals  [LENY];

    conv_stream_driver #(
        .WIDTH(WIDTH), .LENX(LENX), .LENF(LENF),
        .ADDRX(ADDRX), .LENY(LENY), .ADDRY(ADDRY)
    ) dut (
        .clk(clk), .reset(reset),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .start(start), .busy(busy), .done(done),
        .m_data_out_x(m_data_out_x), .m_valid_x(m_valid_x), .m_ready_x(m_ready_x),
        .s_data_in_y(s_data_in_y), .s_valid_y(s_valid_y), .s_ready_y(s_ready_y),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    // Free-running clock, posedges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        vec_cnt++;
        assert (observed === expected) else begin
            err_cnt++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic load_word(input int addr, input logic [WIDTH-1:0] data);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = addr[ADDRX-1:0];
        ld_data = data;
        model_x[addr] = data;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic set_y_ramp();
        for (int i = 0; i < LENY; i++) y_vals[i] = WIDTH'((i + 1) * 10);
    endtask

    task automatic set_y_random();
        for (int i = 0; i < LENY; i++) y_vals[i] = WIDTH'($urandom);
    endtask

    // One run: rmode/vmode pick the x-ready and y-valid patterns
    // (0 = always, 1 = periodic gaps, 2 = random); inject pulses start and
    // ld_en mid-run; ld0 writes x[0] in the same cycle as start; rst_after
    // aborts the run with reset once that many x words have moved.
    task automatic run_once(input int rmode, input int vmode, input bit inject,
                            input bit ld0, input logic [WIDTH-1:0] ld0_val,
                            input int rst_after);
        int tx_idx;
        int ry_idx;
        bit finish_next;
        bit finished;
        bit aborted;
        bit prev_stall;
        bit yv;
        bit exp_rdy;
        bit xfire;
        logic [WIDTH-1:0] prev_data;
        tx_idx = 0; ry_idx = 0; finish_next = 0; finished = 0; aborted = 0;
        prev_stall = 0; prev_data = '0;
        @(negedge clk);
        start = 1'b1;
        if (ld0) begin
            ld_en = 1'b1; ld_addr = '0; ld_data = ld0_val; model_x[0] = ld0_val;
        end
        @(negedge clk);
        start = 1'b0;
        ld_en = 1'b0;
        for (int iter = 0; iter < 400 && !finished && !aborted; iter++) begin
            case (rmode)
                0:       m_ready_x = 1'b1;
                1:       m_ready_x = (iter % 2 == 0);
                default: m_ready_x = 1'($urandom_range(0, 1));
            endcase
            case (vmode)
                0:       yv = 1'b1;
                1:       yv = (iter % 3 == 1);
                default: yv = 1'($urandom_range(0, 1));
            endcase
            s_valid_y   = yv;
            s_data_in_y = (ry_idx < LENY) ? y_vals[ry_idx] : WIDTH'(16'hBEEF);
            if (inject) begin
                start   = (iter == 4);
                ld_en   = (iter == 4);
                ld_addr = '0;
                ld_data = WIDTH'(99);
            end
            #1;
            if (finish_next) begin
                check_output("done_pulse", 32'(done), 32'd1);
                check_output("busy_in_done", 32'(busy), 32'd0);
                check_output("valid_in_done", 32'(m_valid_x), 32'd0);
                check_output("sready_in_done", 32'(s_ready_y), 32'd0);
                finished = 1;
            end else begin
                check_output("done_in_run", 32'(done), 32'd0);
                check_output("busy_in_run", 32'(busy), 32'd1);
                exp_rdy = (ry_idx < LENY);
                check_output("s_ready_y", 32'(s_ready_y), 32'(exp_rdy));
                if (iter >= 1) check_output("m_valid_x", 32'(m_valid_x), 32'(tx_idx < LENX));
                if (prev_stall) check_output("stall_hold", 32'(m_data_out_x), 32'(prev_data));
                xfire = m_valid_x && m_ready_x;
                if (xfire) begin
                    check_output($sformatf("x_word%0d", tx_idx), 32'(m_data_out_x),
                                 32'(model_x[tx_idx < LENX ? tx_idx : 0]));
                    tx_idx++;
                end
                if (yv && exp_rdy) begin
                    model_y[ry_idx] = s_data_in_y;
                    ry_idx++;
                end
                prev_stall  = m_valid_x && !m_ready_x;
                prev_data   = m_data_out_x;
                finish_next = (tx_idx == LENX) && (ry_idx == LENY);
                if (rst_after > 0 && xfire && tx_idx == rst_after) begin
                    @(posedge clk);
                    #2 reset = 1'b1;
                    #1;
                    check_output("rst_valid", 32'(m_valid_x), 32'd0);
                    check_output("rst_busy", 32'(busy), 32'd0);
                    check_output("rst_sready", 32'(s_ready_y), 32'd0);
                    check_output("rst_rd_data", 32'(rd_data), 32'd0);
                    @(negedge clk);
                    reset   = 1'b0;
                    aborted = 1;
                end
            end
            if (!aborted) @(negedge clk);
        end
        start = 1'b0; ld_en = 1'b0; s_valid_y = 1'b0; m_ready_x = 1'b0;
        if (rst_after > 0) begin
            check_output("reset_abort_hit", 32'(aborted), 32'd1);
        end else begin
            check_output("run_completed", 32'(finished), 32'd1);
            check_output("done_one_cycle", 32'(done), 32'd0);
            check_output("idle_after_done", 32'(busy), 32'd0);
        end
    endtask

    // Read back the result buffer while junk y traffic is offered in IDLE.
    task automatic read_back();
        for (int a = 0; a < LENY; a++) begin
            rd_addr     = a[ADDRY-1:0];
            s_valid_y   = 1'b1;
            s_data_in_y = WIDTH'($urandom);
            @(negedge clk);
            check_output($sformatf("rd_y%0d", a), 32'(rd_data), 32'(model_y[a]));
        end
        s_valid_y = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0; start = 1'b0;
        m_ready_x = 1'b0; s_data_in_y = '0; s_valid_y = 1'b0; rd_addr = '0;
        #3;
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_done", 32'(done), 32'd0);
        check_output("reset_valid", 32'(m_valid_x), 32'd0);
        check_output("reset_sready", 32'(s_ready_y), 32'd0);
        check_output("reset_xdata", 32'(m_data_out_x), 32'd0);
        check_output("reset_rd_data", 32'(rd_data), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] x=1..8, ready always high, y every cycle");
        for (int i = 0; i < LENX; i++) load_word(i, WIDTH'(i + 1));
        set_y_ramp();
        run_once(0, 0, 0, 0, '0, 0);
        read_back();

        $display("[TB] alternating ready, gapped y 10..50");
        run_once(1, 1, 0, 0, '0, 0);
        read_back();

        $display("[TB] start/ld_en during run are ignored");
        set_y_random();
        run_once(2, 2, 1, 0, '0, 0);
        read_back();
        run_once(0, 2, 0, 0, '0, 0);
        read_back();

        $display("[TB] reset after third x transfer, then clean rerun");
        run_once(0, 0, 0, 0, '0, 3);
        set_y_ramp();
        run_once(0, 0, 0, 0, '0, 0);
        read_back();

        $display("[TB] ld_en together with start sends the new x[0]");
        run_once(2, 0, 0, 1, WIDTH'(16'h8001), 0);
        read_back();

        $display("[TB] randomized data and handshakes");
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < LENX; i++) load_word(i, WIDTH'($urandom));
            set_y_random();
            run_once(2, 2, 0, 0, '0, 0);
            read_back();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
